// File: rtl/lut4_frame_config_loader_if.sv
// Frame word stream between the tile config port and the LUT4 loader.
// master drives s_data/s_valid, slave returns s_ready.
interface lut4_frame_config_loader_if #(
  parameter int W = 32
);
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/lut4_frame_config_loader.sv
// LUT4 tile config loader: sync/header/data(/checksum) framing into a
// shadow register, committed atomically onto cfg_bits for the BELs.
// Ports: UserCLK, RESETn (async low), s (stream slave), cfg_bits,
// cfg_update (commit pulse), busy (not HUNT), err (sticky).
// Optional macro FRAME_CHECKSUM_EN adds an XOR checksum word.
module lut4_frame_config_loader #(
  parameter int NUM_BELS    = 8,
  parameter int BEL_BITS    = 19,
  parameter int FRAME_WIDTH = 32,
  parameter int NUM_FRAMES  =
    (NUM_BELS * BEL_BITS + FRAME_WIDTH - 1) / FRAME_WIDTH
) (
  input  logic UserCLK,
  input  logic RESETn,
  lut4_frame_config_loader_if.slave s,
  output logic [NUM_BELS*BEL_BITS-1:0] cfg_bits,
  output logic cfg_update,
  output logic busy,
  output logic err
);

  localparam int CFG_W = NUM_BELS * BEL_BITS;
  localparam logic [31:0] SYNC = 32'hFAB0_5EED;

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {
    HUNT, HEADER, DATA, CHECK, COMMIT
  } state_t;
`else
  typedef enum logic [2:0] {
    HUNT, HEADER, DATA, COMMIT
  } state_t;
`endif

  state_t state_q, state_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] rem_q, rem_d;
  logic err_q, err_d;
  logic rdy_q, busy_q, upd_q;
`ifdef FRAME_CHECKSUM_EN
  logic [FRAME_WIDTH-1:0] acc_q, acc_d;
`endif

  logic acc;
  logic [7:0] h_op, h_s, h_n;
  logic [8:0] h_end;
  logic h_ok;
  logic unused_hdr;

  assign acc   = s.s_valid & rdy_q;
  assign h_op  = s.s_data[31:24];
  assign h_s   = s.s_data[15:8];
  assign h_n   = s.s_data[7:0];
  assign h_end = {1'b0, h_s} + {1'b0, h_n};
  assign h_ok  = (h_op == 8'hA5) && (h_n != 8'd0)
              && (h_end <= 9'(NUM_FRAMES));
  assign unused_hdr = ^s.s_data[23:16];

  always_comb begin
    int base;
    state_d  = state_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    err_d    = err_q;
`ifdef FRAME_CHECKSUM_EN
    acc_d    = acc_q;
`endif
    base     = int'(ptr_q) * FRAME_WIDTH;
    unique case (state_q)
      HUNT: begin
        if (acc && s.s_data == SYNC) begin
          err_d   = 1'b0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (acc) begin
          if (h_ok) begin
            shadow_d = cfg_q;
            ptr_d    = h_s;
            rem_d    = h_n;
`ifdef FRAME_CHECKSUM_EN
            acc_d    = '0;
`endif
            state_d  = DATA;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
        end
      end
      DATA: begin
        if (acc) begin
          // bits past CFG_W in the last frame fall off here
          for (int i = 0; i < CFG_W; i++) begin
            if (i >= base && i < base + FRAME_WIDTH)
              shadow_d[i] = s.s_data[i - base];
          end
          ptr_d = ptr_q + 8'd1;
          rem_d = rem_q - 8'd1;
`ifdef FRAME_CHECKSUM_EN
          acc_d = acc_q ^ s.s_data;
          if (rem_q == 8'd1)
            state_d = CHECK;
`else
          if (rem_q == 8'd1)
            state_d = COMMIT;
`endif
        end
      end
`ifdef FRAME_CHECKSUM_EN
      CHECK: begin
        if (acc) begin
          if (s.s_data == acc_q) begin
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
        end
      end
`endif
      COMMIT: begin
        cfg_d   = shadow_q;
        state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      cfg_q    <= '0;
      ptr_q    <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      upd_q    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      rdy_q    <= (state_d != COMMIT);
      busy_q   <= (state_d != HUNT);
      upd_q    <= (state_d == COMMIT);
`ifdef FRAME_CHECKSUM_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign s.s_ready  = rdy_q;
  assign cfg_bits   = cfg_q;
  assign cfg_update = upd_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
